// File: rtl/sha256_pkg.sv
// Shared constants, block-count helper and FSM encoding
// for the SHA-256 message padder.
package sha256_pkg;

    localparam int SHA256_BLK_WORDS = 16;
    localparam logic [31:0] SHA256_PAD_WORD = 32'h8000_0000;

    // Message + pad word + two length words, rounded up to whole blocks.
    function automatic int sha256_num_blocks(input int nw);
        return (nw + 2) / SHA256_BLK_WORDS + 1;
    endfunction

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        CAPT,
        EMIT,
        DONE
    } padder_state_t;

endpackage

// File: rtl/sha256_pad_word_gen.sv
// Classifies a padded-message word index as message or padding
// and produces the padding/length word for the padding positions.
module sha256_pad_word_gen
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 30,
    parameter int WC_W = 6
) (
    input  logic [WC_W-1:0] wc,
    output logic            is_msg,
    output logic [31:0]     pad_word
);

    localparam int TOTAL = SHA256_BLK_WORDS * sha256_num_blocks(NUM_OF_WORDS);
    localparam logic [WC_W-1:0] PAD_WC = WC_W'(NUM_OF_WORDS);
    localparam logic [WC_W-1:0] LEN_WC = WC_W'(TOTAL - 1);
    localparam logic [31:0] LEN_WORD = 32'(NUM_OF_WORDS * 32);

    assign is_msg = wc < PAD_WC;

    always_comb begin
        pad_word = '0;
        unique case (1'b1)
            (wc == PAD_WC): pad_word = SHA256_PAD_WORD;
            (wc == LEN_WC): pad_word = LEN_WORD;
            default:        pad_word = '0;
        endcase
    end

endmodule

// File: rtl/sha256_msg_padder.sv
// Reads a message from word memory, appends SHA-256 padding and streams it.
// Define SHA_PAD_BSWAP_EN to byte-reverse each message word read from memory.
module sha256_msg_padder
    import sha256_pkg::*;
#(
    parameter int NUM_OF_WORDS = 30,
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] message_addr,
    output logic              busy,
    output logic              done,
    output logic              mem_clk,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [31:0]       mem_read_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_word,
    output logic [3:0]        out_idx,
    output logic              out_blk_last,
    output logic              out_last
);

    localparam int TOTAL = SHA256_BLK_WORDS * sha256_num_blocks(NUM_OF_WORDS);
    localparam int WC_W = $clog2(TOTAL);
    localparam logic [WC_W-1:0] LAST_WC = WC_W'(TOTAL - 1);

    padder_state_t state, state_nxt;

    logic [ADDR_W-1:0] msg_base;
    logic [WC_W-1:0]   wc;
    logic [WC_W-1:0]   wc_nxt;
    logic              nxt_is_msg;
    logic              last_word;
    logic              hs;
    logic [31:0]       nxt_pad;
    logic [31:0]       cap_word;

    assign mem_clk   = clk;
    assign mem_we    = 1'b0;
    assign busy      = state != IDLE;
    assign done      = state == DONE;
    assign hs        = out_valid && out_ready;
    assign wc_nxt    = wc + WC_W'(1);
    assign last_word = wc == LAST_WC;

`ifdef SHA_PAD_BSWAP_EN
    assign cap_word = {mem_read_data[7:0], mem_read_data[15:8],
                       mem_read_data[23:16], mem_read_data[31:24]};
`else
    assign cap_word = mem_read_data;
`endif

    // Classification is always for the word that follows the current one.
    sha256_pad_word_gen #(
        .NUM_OF_WORDS(NUM_OF_WORDS),
        .WC_W        (WC_W)
    ) u_gen (
        .wc      (wc_nxt),
        .is_msg  (nxt_is_msg),
        .pad_word(nxt_pad)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (start) state_nxt = FETCH;
            FETCH: state_nxt = WAIT;
            WAIT:  state_nxt = CAPT;
            CAPT:  state_nxt = EMIT;
            EMIT: begin
                if (hs) begin
                    if (last_word)       state_nxt = DONE;
                    else if (nxt_is_msg) state_nxt = FETCH;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            msg_base     <= '0;
            wc           <= '0;
            mem_addr     <= '0;
            out_word     <= '0;
            out_idx      <= '0;
            out_valid    <= 1'b0;
            out_blk_last <= 1'b0;
            out_last     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        msg_base <= message_addr;
                        wc       <= '0;
                        out_idx  <= '0;
                    end
                end
                FETCH: mem_addr <= msg_base + ADDR_W'(wc);
                CAPT: begin
                    out_word     <= cap_word;
                    out_valid    <= 1'b1;
                    out_blk_last <= out_idx == 4'd15;
                    out_last     <= last_word;
                end
                EMIT: begin
                    if (hs) begin
                        wc      <= wc_nxt;
                        out_idx <= out_idx + 4'd1;
                        if (last_word || nxt_is_msg) begin
                            out_valid    <= 1'b0;
                            out_blk_last <= 1'b0;
                            out_last     <= 1'b0;
                        end else begin
                            // Padding streams back-to-back without leaving EMIT.
                            out_word     <= nxt_pad;
                            out_blk_last <= out_idx == 4'd14;
                            out_last     <= wc_nxt == LAST_WC;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
